// File: rtl/mem_pkg.sv
// ============================================================================
//  Module   : mem_pkg
//  Purpose  : Shared definitions for the main memory model: FSM state
//             encoding, default latencies, out-of-range fill pattern and
//             the power-on content function.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package mem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } mem_state_t;

    localparam int          c_READ_LATENCY_DEFAULT  = 10;
    localparam int          c_WRITE_LATENCY_DEFAULT = 6;
    localparam logic [31:0] c_DEADBEEF_FILL         = 32'hDEAD_BEEF;

    // Power-on content: word w of block b holds b*words_per_block + w.
    function automatic logic [31:0] init_word(input int unsigned blk,
                                              input int unsigned word,
                                              input int unsigned words_per_block);
        return 32'(blk * words_per_block + word);
    endfunction

endpackage : mem_pkg

`default_nettype wire

// File: rtl/mem_latency_timer.sv
// ============================================================================
//  Module   : mem_latency_timer
//  Purpose  : Loadable down-counter that paces a memory request.
//  Ports    : clk, rst_n (sync, active-low)
//             load      - load load_val into the counter
//             load_val  - latency minus one
//             done      - high in the cycle whose decrement reaches zero
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module mem_latency_timer #(
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             done
);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (load) begin
            r_count <= load_val;
        end else if (r_count != '0) begin
            r_count <= r_count - CNT_W'(1);
        end
    end

    // The FSM leaves BUSY on the same edge the count lands on zero.
    assign done = (r_count == CNT_W'(1));

endmodule : mem_latency_timer

`default_nettype wire

// File: rtl/main_memory_model.sv
// ============================================================================
//  Module   : main_memory_model
//  Purpose  : Block-granular backing store behind the L2. Accepts one
//             request at a time, completes it after a fixed latency with a
//             one-cycle mem_hit pulse and a full response block.
//  Ports    : clk, rst_n (sync, active-low)
//             mem_addr     - request address (offset bits ignored)
//             mem_data_in  - write block
//             mem_read     - read request level
//             mem_write    - write request level (wins over read)
//             mem_data_out - response block, held until next response
//             mem_ready    - idle, request will be accepted
//             mem_hit      - completion pulse
//  Config   : MAIN_MEM_ADDR_CHECK_EN - flag addresses with nonzero bits
//             above the block index; such writes are dropped and every
//             response word is the DEADBEEF fill.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module main_memory_model
    import mem_pkg::*;
#(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDR_WIDTH    = 32,
    parameter int BLOCK_SIZE    = 16,
    parameter int MEM_BLOCKS    = 256,
    parameter int READ_LATENCY  = c_READ_LATENCY_DEFAULT,
    parameter int WRITE_LATENCY = c_WRITE_LATENCY_DEFAULT
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic [ADDR_WIDTH-1:0]                 mem_addr,
    input  logic [BLOCK_SIZE-1:0][DATA_WIDTH-1:0] mem_data_in,
    input  logic                                  mem_read,
    input  logic                                  mem_write,
    output logic [BLOCK_SIZE-1:0][DATA_WIDTH-1:0] mem_data_out,
    output logic                                  mem_ready,
    output logic                                  mem_hit
);

    localparam int c_OFF_W   = $clog2(BLOCK_SIZE);
    localparam int c_IDX_W   = $clog2(MEM_BLOCKS);
    localparam int c_MAX_LAT = (READ_LATENCY > WRITE_LATENCY) ? READ_LATENCY : WRITE_LATENCY;
    localparam int c_CNT_W   = $clog2(c_MAX_LAT) + 1;

    localparam logic [c_CNT_W-1:0] c_RD_LAT_M1 = c_CNT_W'(READ_LATENCY - 1);
    localparam logic [c_CNT_W-1:0] c_WR_LAT_M1 = c_CNT_W'(WRITE_LATENCY - 1);

    typedef logic [BLOCK_SIZE-1:0][DATA_WIDTH-1:0] block_t;

    // ------------------------------------------------------------------
    // Storage. r_written marks blocks overwritten since power-on; an
    // unwritten block reads back its computed power-on pattern. Neither
    // array is touched by reset.
    // ------------------------------------------------------------------
    block_t                  r_mem [MEM_BLOCKS];
    logic [MEM_BLOCKS-1:0]   r_written = '0;

    mem_state_t              r_state;
    logic [c_IDX_W-1:0]      r_idx;
    block_t                  r_wdata;
    logic                    r_is_write;
    logic                    r_oor;

    logic                    w_req;
    logic                    w_accept;
    logic                    w_enter_resp;
    logic                    w_commit;
    logic                    w_timer_done;
    logic [c_CNT_W-1:0]      w_lat_m1;
    logic [c_IDX_W-1:0]      w_live_idx;
    logic                    w_live_oor;
    logic [c_IDX_W-1:0]      w_sel_idx;
    block_t                  w_sel_wdata;
    logic                    w_sel_write;
    logic                    w_sel_oor;
    block_t                  w_init_block;
    block_t                  w_fill_block;
    block_t                  w_rd_block;
    block_t                  w_resp_block;
    logic                    w_unused_addr;

    assign w_req      = mem_read | mem_write;
    assign w_accept   = (r_state == ST_IDLE) && w_req;
    assign w_lat_m1   = mem_write ? c_WR_LAT_M1 : c_RD_LAT_M1;
    assign w_live_idx = mem_addr[c_OFF_W +: c_IDX_W];

    // Offset bits (and upper bits when unchecked) carry no meaning here.
    assign w_unused_addr = ^mem_addr;

`ifdef MAIN_MEM_ADDR_CHECK_EN
    localparam int c_HI = c_OFF_W + c_IDX_W;
    assign w_live_oor = (c_HI < ADDR_WIDTH) ? |(mem_addr >> c_HI) : 1'b0;
`else
    assign w_live_oor = 1'b0;
`endif

    // A single-cycle latency responds on the accepting edge, so the live
    // request fields are used in IDLE and the latched ones afterwards.
    assign w_sel_idx   = (r_state == ST_IDLE) ? w_live_idx  : r_idx;
    assign w_sel_wdata = (r_state == ST_IDLE) ? mem_data_in : r_wdata;
    assign w_sel_write = (r_state == ST_IDLE) ? mem_write   : r_is_write;
    assign w_sel_oor   = (r_state == ST_IDLE) ? w_live_oor  : r_oor;

    always_comb begin
        w_init_block = '0;
        w_fill_block = '0;
        for (int w = 0; w < BLOCK_SIZE; w++) begin
            w_init_block[w] = DATA_WIDTH'(init_word(int'(w_sel_idx), w, BLOCK_SIZE));
            w_fill_block[w] = DATA_WIDTH'(c_DEADBEEF_FILL);
        end
    end

    assign w_rd_block   = r_written[w_sel_idx] ? r_mem[w_sel_idx] : w_init_block;
    assign w_resp_block = w_sel_oor   ? w_fill_block :
                          w_sel_write ? w_sel_wdata  : w_rd_block;

    assign w_enter_resp = (w_accept && (w_lat_m1 == '0)) ||
                          ((r_state == ST_BUSY) && w_timer_done);

    // Reset on the commit edge wins: the write is discarded.
    assign w_commit = rst_n && w_enter_resp && w_sel_write && !w_sel_oor;

    always_ff @(posedge clk) begin
        if (w_commit) begin
            r_mem[w_sel_idx]     <= w_sel_wdata;
            r_written[w_sel_idx] <= 1'b1;
        end
    end

    mem_latency_timer #(
        .CNT_W    (c_CNT_W)
    ) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (w_accept),
        .load_val (w_lat_m1),
        .done     (w_timer_done)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_idx        <= '0;
            r_wdata      <= '0;
            r_is_write   <= 1'b0;
            r_oor        <= 1'b0;
            mem_ready    <= 1'b1;
            mem_hit      <= 1'b0;
            mem_data_out <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_req) begin
                        r_idx      <= w_live_idx;
                        r_wdata    <= mem_data_in;
                        r_is_write <= mem_write;
                        r_oor      <= w_live_oor;
                        mem_ready  <= 1'b0;
`ifdef MAIN_MEM_ADDR_CHECK_EN
                        if (w_live_oor) begin
                            $display("main_memory_model: warning, out-of-range address 0x%h", mem_addr);
                        end
`endif
                        if (w_lat_m1 == '0) begin
                            r_state      <= ST_RESP;
                            mem_hit      <= 1'b1;
                            mem_data_out <= w_resp_block;
                        end else begin
                            r_state <= ST_BUSY;
                        end
                    end
                end
                ST_BUSY: begin
                    if (w_timer_done) begin
                        r_state      <= ST_RESP;
                        mem_hit      <= 1'b1;
                        mem_data_out <= w_resp_block;
                    end
                end
                ST_RESP: begin
                    r_state   <= ST_IDLE;
                    mem_hit   <= 1'b0;
                    mem_ready <= 1'b1;
                end
                default: begin
                    r_state   <= ST_IDLE;
                    mem_hit   <= 1'b0;
                    mem_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule : main_memory_model

`default_nettype wire
